// File: rtl/res_sched_pkg.sv
// Shared types and helpers for the resistor-programming SPI scheduler.
package res_sched_pkg;

  localparam int MAX_CS = 16;
  localparam logic [MAX_CS-1:0] CS_INACTIVE = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  // Circular search over the low n bits of vec, starting at index start (start < n).
  function automatic logic [3:0] first_set(input logic [MAX_CS-1:0] vec,
                                           input logic [3:0] start,
                                           input int n);
    logic [3:0] sel;
    logic found;
    int idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CS; i++) begin
      idx = int'(start) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && vec[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/res_spi_shifter.sv
// Mode-0 serialiser: CLK_DIV prescaler, bit counter and MSB-first shift register.
module res_spi_shifter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  output logic              ResClk,
  output logic              ResSDI,
  output logic              last_bit
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  logic              active_q, active_d;
  logic              clk_q, clk_d;
  logic [CW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sr_q, sr_d;

  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    if (load) sr_d = load_data;
    if (start) begin
      active_d = 1'b1;
      clk_d    = 1'b0;
      div_d    = DIV_MAX;
      bit_d    = BIT_MAX;
    end else if (active_q) begin
      if (div_q == '0) begin
        div_d = DIV_MAX;
        clk_d = ~clk_q;
        if (clk_q) begin
          // The LSB is left in place so it stays on ResSDI through HOLD.
          if (bit_q == '0) begin
            active_d = 1'b0;
          end else begin
            bit_d = bit_q - BW'(1);
            sr_d  = {sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q - CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      active_q <= 1'b0;
      clk_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
    end
  end

  assign ResClk   = clk_q;
  assign ResSDI   = sr_q[DATA_W-1];
  assign last_bit = active_q && clk_q && (div_q == '0) && (bit_q == '0);

endmodule

// File: rtl/res_spi_scheduler.sv
// Arbitrates shadow-register channels onto the shared ResClk/ResSDI bus with per-channel ResCS.
// Build option: RES_SCHED_RR_EN selects round-robin grant instead of fixed lowest-index priority.
//
// state | meaning
// IDLE  | waiting for a pending channel; grants on the edge it sees one
// SETUP | ResCS low, ResClk low, MSB on ResSDI for CLK_DIV cycles
// SHIFT | DATA_W clock periods driven by the shifter
// HOLD  | ResClk low, ResCS still low, LSB held
// GAP   | all ResCS high; done pulses in the final cycle
module res_spi_scheduler
  import res_sched_pkg::*;
#(
  parameter int NUM_CS  = 8,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic [NUM_CS-1:0]         ResCS,
  output logic                      ResClk,
  output logic                      ResSDI,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NUM_CS)-1:0] done_ch,
  output logic [NUM_CS-1:0]         pending
);

  localparam int AW  = $clog2(NUM_CS);
  localparam int AW1 = AW + 1;
  localparam int CW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     cs_ch_q, cs_ch_d;
  logic [NUM_CS-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] shadow_q [NUM_CS];
  logic [DATA_W-1:0] shadow_d [NUM_CS];

  logic              wr_ok, grant_fire, sh_load, sh_start, last_bit, sh_sdi, active;
  logic [AW-1:0]     grant;
  logic [MAX_CS-1:0] pend_ext;
  logic [3:0]        start_ext;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < AW1'(NUM_CS));

  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_CS-1:0] = pending_q;
  end

`ifdef RES_SCHED_RR_EN
  localparam logic [AW-1:0] LAST_CH = AW'(NUM_CS - 1);
  logic [AW-1:0] rr_start_q, rr_start_d;

  always_comb begin
    rr_start_d = rr_start_q;
    if (grant_fire) rr_start_d = (grant == LAST_CH) ? '0 : grant + AW'(1);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) rr_start_q <= '0;
    else     rr_start_q <= rr_start_d;
  end

  assign start_ext = 4'(rr_start_q);
`else
  assign start_ext = '0;
`endif

  assign grant = AW'(first_set(pend_ext, start_ext, NUM_CS));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_ch_d    = cs_ch_q;
    grant_fire = 1'b0;
    sh_load    = 1'b0;
    sh_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_fire = 1'b1;
          sh_load    = 1'b1;
          cs_ch_d    = grant;
          cnt_d      = CNT_MAX;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          sh_start = 1'b1;
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_d   = CNT_MAX;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle write to the granted channel wins, so its new word is queued.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (grant_fire) pending_d[grant] = 1'b0;
    if (wr_ok) begin
      shadow_d[wr_addr]  = wr_data;
      pending_d[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cs_ch_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_CS; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_ch_q   <= cs_ch_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
    end
  end

  res_spi_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (sh_load),
    .load_data (shadow_q[grant]),
    .start     (sh_start),
    .ResClk    (ResClk),
    .ResSDI    (sh_sdi),
    .last_bit  (last_bit)
  );

  assign active = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

  always_comb begin
    ResCS = CS_INACTIVE[NUM_CS-1:0];
    if (active) ResCS[cs_ch_q] = 1'b0;
  end

  assign ResSDI  = active & sh_sdi;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == GAP) && (cnt_q == '0);
  assign done_ch = cs_ch_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_res_spi_scheduler.sv
// Directed self-checking bench for res_spi_scheduler (8-channel default plus a 5-channel instance).
module tb_res_spi_scheduler;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  ResCS;
  logic        ResClk, ResSDI, busy, done;
  logic [2:0]  done_ch;
  logic [7:0]  pending;

  logic        s_wr_en = 1'b0;
  logic [2:0]  s_wr_addr = '0;
  logic [7:0]  s_wr_data = '0;
  logic [4:0]  s_cs;
  logic        s_clk, s_sdi, s_busy, s_done;
  logic [2:0]  s_done_ch;
  logic [4:0]  s_pending;

  always #5 Clk = ~Clk;

  res_spi_scheduler #(.NUM_CS(8), .DATA_W(16), .CLK_DIV(4)) dut (
    .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ResCS(ResCS), .ResClk(ResClk), .ResSDI(ResSDI), .busy(busy), .done(done),
    .done_ch(done_ch), .pending(pending)
  );

  res_spi_scheduler #(.NUM_CS(5), .DATA_W(8), .CLK_DIV(1)) u_small (
    .Clk(Clk), .Rst(Rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .ResCS(s_cs), .ResClk(s_clk), .ResSDI(s_sdi), .busy(s_busy), .done(s_done),
    .done_ch(s_done_ch), .pending(s_pending)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: reconstructs each transfer from ResClk rising edges.
  logic [15:0] cur_word;
  int          cur_bits, cs_cyc, busy_cyc, cs_total;
  logic        prev_clk;
  logic [7:0]  last_cs;
  int          q_ch[$];
  logic [15:0] q_word[$];
  int          q_bits[$], q_cs[$], q_busy[$];
  logic [7:0]  q_csval[$];
  int          s_cs_seen, s_done_cnt;
  logic [2:0]  s_done_last;

  initial begin
    cur_word = '0; cur_bits = 0; cs_cyc = 0; busy_cyc = 0; cs_total = 0;
    prev_clk = 1'b0; last_cs = 8'hFF; s_cs_seen = 0; s_done_cnt = 0; s_done_last = '0;
  end

  always @(negedge Clk) begin
    if (Rst) begin
      cur_word = '0; cur_bits = 0; cs_cyc = 0; busy_cyc = 0; prev_clk = 1'b0;
    end else begin
      if (ResClk && !prev_clk) begin
        cur_word = {cur_word[14:0], ResSDI};
        cur_bits++;
      end
      prev_clk = ResClk;
      if (ResCS != 8'hFF) begin
        cs_cyc++;
        cs_total++;
        last_cs = ResCS;
      end
      if (busy) busy_cyc++;
      chk("cs_onehot", 32'($countones(~ResCS) <= 1), 1);
      chk("clk_without_cs", 32'(ResClk && (ResCS == 8'hFF)), 0);
      chk("cs_while_idle", 32'((ResCS != 8'hFF) && !busy), 0);
      if (ResCS == 8'hFF) chk("sdi_idle_low", 32'(ResSDI), 0);
      if (done) begin
        q_ch.push_back(int'(done_ch));
        q_word.push_back(cur_word);
        q_bits.push_back(cur_bits);
        q_cs.push_back(cs_cyc);
        q_busy.push_back(busy_cyc);
        q_csval.push_back(last_cs);
        cur_word = '0; cur_bits = 0; cs_cyc = 0; busy_cyc = 0;
      end
      if (s_cs != 5'h1F) s_cs_seen++;
      if (s_done) begin
        s_done_cnt++;
        s_done_last = s_done_ch;
      end
    end
  end

  task automatic drive(input logic [2:0] a, input logic [15:0] d);
    @(negedge Clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic release_wr();
    @(negedge Clk);
    wr_en = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (q_ch.size() < n && k < budget) begin
      @(negedge Clk); #1; k++;
    end
    chk(tag, 32'(q_ch.size() >= n), 1);
  endtask

  task automatic wait_bits(input int n, input int budget, input string tag);
    int k = 0;
    while (!(busy && cur_bits >= n) && k < budget) begin
      @(negedge Clk); #1; k++;
    end
    chk(tag, 32'(cur_bits >= n), 1);
  endtask

  task automatic chk_xfer(input int idx, input int ch, input logic [15:0] word, input string tag);
    chk({tag, "_ch"},   32'(q_ch[idx]), 32'(ch));
    chk({tag, "_word"}, 32'(q_word[idx]), 32'(word));
    chk({tag, "_bits"}, 32'(q_bits[idx]), 16);
  endtask

  initial begin
    int base_done, base_cs, k;
    int ord0, ord1, ord2;

    // Reset values
    #12;
    chk("rst_cs", 32'(ResCS), 32'h0FF);
    chk("rst_clk", 32'(ResClk), 0);
    chk("rst_sdi", 32'(ResSDI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_ch", 32'(done_ch), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_small_cs", 32'(s_cs), 32'h1F);
    @(negedge Clk);
    Rst = 1'b0;

    // Single transfer on ch3
    drive(3'd3, 16'hA5C3);
    release_wr();
    wait_done(1, 200, "t1_timeout");
    chk_xfer(0, 3, 16'hA5C3, "t1");
    chk("t1_cs_value", 32'(q_csval[0]), 32'h0F7);
    chk("t1_cs_cycles", 32'(q_cs[0]), 136);
    chk("t1_busy_cycles", 32'(q_busy[0]), 140);
    chk("t1_pending", 32'(pending), 0);

    // Out-of-range addresses on the 5-channel instance
    @(negedge Clk); s_wr_en = 1'b1; s_wr_addr = 3'd5; s_wr_data = 8'h11;
    @(negedge Clk); s_wr_addr = 3'd6;
    @(negedge Clk); s_wr_addr = 3'd7;
    @(negedge Clk); s_wr_en = 1'b0;
    repeat (5) @(negedge Clk);
    #1;
    chk("t5_pending", 32'(s_pending), 0);
    chk("t5_busy", 32'(s_busy), 0);
    chk("t5_no_cs", 32'(s_cs_seen), 0);
    chk("t5_no_done", 32'(s_done_cnt), 0);
    @(negedge Clk); s_wr_en = 1'b1; s_wr_addr = 3'd4; s_wr_data = 8'h5A;
    @(negedge Clk); s_wr_en = 1'b0;
    #1;
    chk("t5_inrange_pending", 32'(s_pending), 32'h10);
    k = 0;
    while (s_done_cnt == 0 && k < 40) begin @(negedge Clk); #1; k++; end
    chk("t5_inrange_done", 32'(s_done_cnt), 1);
    chk("t5_inrange_ch", 32'(s_done_last), 4);

    // Three writes in consecutive idle cycles: ch5 is granted before the others land
    drive(3'd5, 16'h5555);
    drive(3'd1, 16'h1001);
    drive(3'd6, 16'h6C6C);
    release_wr();
`ifdef RES_SCHED_RR_EN
    ord0 = 5; ord1 = 6; ord2 = 1;
`else
    ord0 = 5; ord1 = 1; ord2 = 6;
`endif
    wait_done(4, 600, "t2_timeout");
    chk("t2_first", 32'(q_ch[1]), 32'(ord0));
    chk("t2_second", 32'(q_ch[2]), 32'(ord1));
    chk("t2_third", 32'(q_ch[3]), 32'(ord2));
    chk("t2_word5", 32'(q_word[1]), 32'h5555);
    chk("t2_word_last", 32'(q_word[3]), (ord2 == 6) ? 32'h6C6C : 32'h1001);

    // Rewrite of the channel in flight
    drive(3'd2, 16'h1111);
    release_wr();
    wait_bits(8, 200, "t3_bit8_timeout");
    drive(3'd2, 16'h2222);
    release_wr();
    chk("t3_pending_set", 32'(pending[2]), 1);
    chk("t3_busy", 32'(busy), 1);
    wait_done(5, 200, "t3_first_timeout");
    chk_xfer(4, 2, 16'h1111, "t3_first");
    chk("t3_done_pending", 32'(pending[2]), 1);
    @(negedge Clk); #1;
    chk("t3_idle_busy", 32'(busy), 0);
    chk("t3_idle_pending", 32'(pending[2]), 1);
    @(negedge Clk); #1;
    chk("t3_regrant_busy", 32'(busy), 1);
    chk("t3_regrant_pending", 32'(pending[2]), 0);
    wait_done(6, 200, "t3_second_timeout");
    chk_xfer(5, 2, 16'h2222, "t3_second");

    // Write to the channel on its grant cycle
    drive(3'd4, 16'hAAAA);
    drive(3'd4, 16'hBBBB);
    release_wr();
    chk("t6_busy", 32'(busy), 1);
    chk("t6_pending", 32'(pending[4]), 1);
    wait_done(7, 200, "t6_first_timeout");
    chk_xfer(6, 4, 16'hAAAA, "t6_old");
    wait_done(8, 200, "t6_second_timeout");
    chk_xfer(7, 4, 16'hBBBB, "t6_new");
    chk("t6_pending_clear", 32'(pending), 0);

    // Asynchronous reset mid-SHIFT
    drive(3'd7, 16'h1234);
    release_wr();
    wait_bits(5, 200, "t4_bit5_timeout");
    #2;
    Rst = 1'b1;
    #1;
    chk("t4_cs", 32'(ResCS), 32'h0FF);
    chk("t4_clk", 32'(ResClk), 0);
    chk("t4_sdi", 32'(ResSDI), 0);
    chk("t4_pending", 32'(pending), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    base_done = q_ch.size();
    base_cs   = cs_total;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (200) @(negedge Clk);
    #1;
    chk("t4_no_done", 32'(q_ch.size()), 32'(base_done));
    chk("t4_no_traffic", 32'(cs_total), 32'(base_cs));
    chk("t4_idle_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
